// File: rtl/mdu_e.sv
// rtl/mdu_e.sv - E-stage multiply/divide unit owning the HI/LO registers
//
// Purpose: accepts mult/multu/div/divu from the D/E register, computes the
// 64-bit {hi,lo} result up front into a pending register, holds busy for a
// fixed latency, then commits the result to HI/LO. mthi/mtlo write HI/LO
// directly when idle; mfhi/mflo read them combinationally on mf_out.
//
// Ports:
//   clk     in   1  system clock, rising edge
//   reset   in   1  asynchronous active-high reset
//   start   in   1  qualifies a mult/multu/div/divu in MDUOp
//   MDUOp   in   4  0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo
//   A       in  32  operand rs
//   B       in  32  operand rt
//   busy    out  1  operation in flight (registered)
//   HI      out 32  architectural HI
//   LO      out 32  architectural LO
//   mf_out  out 32  HI for mfhi, LO for mflo, else 0
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mf_out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e        state_q;
  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   pend_hi_q, pend_lo_q;

  logic [63:0]   prod_s, prod_u;
  logic [31:0]   abs_a, abs_b, udiv_q, udiv_r, quo_s, rem_s;
  logic [31:0]   res_hi_d, res_lo_d;
  logic          is_md_op;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide through magnitudes: the quotient magnitude of
  // 0x80000000 / -1 is 0x80000000, which is already the wrapped answer.
  assign abs_a  = A[31] ? -A : A;
  assign abs_b  = B[31] ? -B : B;
  assign udiv_q = abs_a / abs_b;
  assign udiv_r = abs_a % abs_b;
  assign quo_s  = (A[31] ^ B[31]) ? -udiv_q : udiv_q;
  assign rem_s  = A[31] ? -udiv_r : udiv_r;

  assign is_md_op = (MDUOp >= 4'd1) && (MDUOp <= 4'd4);

  // Divide by zero keeps the current HI/LO as the pending value, so the
  // commit at the end of the busy window leaves them unchanged.
  always_comb begin
    res_hi_d = hi_q;
    res_lo_d = lo_q;
    case (MDUOp)
      4'd1: {res_hi_d, res_lo_d} = prod_s;
      4'd2: {res_hi_d, res_lo_d} = prod_u;
      4'd3: if (B != 32'd0) begin
        res_hi_d = rem_s;
        res_lo_d = quo_s;
      end
      4'd4: if (B != 32'd0) begin
        res_hi_d = A % B;
        res_lo_d = A / B;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && is_md_op) begin
            pend_hi_q <= res_hi_d;
            pend_lo_q <= res_lo_d;
            cnt_q     <= (MDUOp <= 4'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            state_q   <= S_BUSY;
            busy_q    <= 1'b1;
          end
          if (MDUOp == 4'd7) hi_q <= A;
          if (MDUOp == 4'd8) lo_q <= A;
        end
        S_BUSY: begin
          if (cnt_q == CW'(1)) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            cnt_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign mf_out = (MDUOp == 4'd5) ? hi_q :
                  (MDUOp == 4'd6) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_e.sv
// tb/tb_mdu_e.sv - self-checking bench for mdu_e
module tb_mdu_e;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  MDUOp = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI, LO, mf_out;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .mf_out(mf_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference from architectural rules using wide integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return 64'(ua * ub);
      4'd3: if (b == 32'd0) return {hi, lo};
            else return {32'(sa % sb), 32'(sa / sb)};
      4'd4: if (b == 32'd0) return {hi, lo};
            else return {32'(ua % ub), 32'(ua / ub)};
      default: return {hi, lo};
    endcase
  endfunction

  task automatic check_mf(input string tag);
    MDUOp = 4'd5; #1;
    chk({tag, " mfhi"}, mf_out, m_hi);
    MDUOp = 4'd6; #1;
    chk({tag, " mflo"}, mf_out, m_lo);
    MDUOp = 4'd0; #1;
    chk({tag, " mf none"}, mf_out, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int cnt;
    @(negedge clk);
    start = 1'b1; MDUOp = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; MDUOp = 4'd0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, 32'(cnt), (op <= 4'd2) ? 32'(MC) : 32'(DC));
    chk({tag, " HI"}, HI, ehi);
    chk({tag, " LO"}, LO, elo);
    m_hi = ehi;
    m_lo = elo;
    check_mf(tag);
  endtask

  task automatic run_mt(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk);
    start = 1'($urandom_range(0, 1)); MDUOp = op; A = a;
    @(negedge clk);
    start = 1'b0; MDUOp = 4'd0;
    #1;
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " HI"}, HI, ehi);
    chk({tag, " LO"}, LO, elo);
    m_hi = ehi;
    m_lo = elo;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{4'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{4'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC};
    vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{4'd7, 32'h12345678, 32'd0,        32'h12345678, 32'h80000000};
    vecs[6] = '{4'd8, 32'h00000009, 32'd0,        32'h12345678, 32'h00000009};
    vecs[7] = '{4'd3, 32'h00000005, 32'd0,        32'h12345678, 32'h00000009};
    vecs[8] = '{4'd4, 32'h00000007, 32'd0,        32'h12345678, 32'h00000009};

    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    reset = 1'b0;
    check_mf("reset");

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].op >= 4'd7)
        run_mt($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].hi, vecs[i].lo);
      else
        run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
    end

    // Second start and an mthi during busy must both be ignored.
    begin
      int cnt;
      @(negedge clk);
      start = 1'b1; MDUOp = 4'd1; A = 32'd7; B = 32'd3;
      @(negedge clk);
      start = 1'b0; MDUOp = 4'd0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
        cnt++;
        if (cnt == 2) begin
          start = 1'b1; MDUOp = 4'd2; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
        end else if (cnt == 3) begin
          start = 1'b0; MDUOp = 4'd7; A = 32'hDEADBEEF;
        end else begin
          start = 1'b0; MDUOp = 4'd0;
        end
        @(negedge clk);
      end
      MDUOp = 4'd0;
      chk("restart busy cycles", 32'(cnt), 32'(MC));
      chk("restart HI", HI, 32'd0);
      chk("restart LO", LO, 32'd21);
      m_hi = 32'd0;
      m_lo = 32'd21;
      @(negedge clk);
      chk("restart idle", {31'd0, busy}, 32'd0);
    end

    // Asynchronous reset part-way through a divide.
    begin
      @(negedge clk);
      start = 1'b1; MDUOp = 4'd3; A = 32'd100; B = 32'd7;
      @(negedge clk);
      start = 1'b0; MDUOp = 4'd0;
      repeat (3) @(negedge clk);
      chk("pre-reset busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async reset busy", {31'd0, busy}, 32'd0);
      chk("async reset HI", HI, 32'd0);
      chk("async reset LO", LO, 32'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      reset = 1'b0;
      repeat (DC + 3) @(negedge clk);
      chk("post-reset busy", {31'd0, busy}, 32'd0);
      chk("post-reset HI", HI, 32'd0);
      chk("post-reset LO", LO, 32'd0);
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [63:0] r;
      case ($urandom_range(0, 5))
        0: op = 4'd1;
        1: op = 4'd2;
        2: op = 4'd3;
        3: op = 4'd4;
        4: op = 4'd7;
        default: op = 4'd8;
      endcase
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 16));
        3: a = -32'($urandom_range(1, 1000));
        default: ;
      endcase
      if (op == 4'd7)
        run_mt($sformatf("rnd%0d", i), op, a, a, m_lo);
      else if (op == 4'd8)
        run_mt($sformatf("rnd%0d", i), op, a, m_hi, a);
      else begin
        r = ref_result(op, a, b, m_hi, m_lo);
        run_op($sformatf("rnd%0d", i), op, a, b, r[63:32], r[31:0]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_e.md
Name: mdu_e

Overview:
- E-stage multiply/divide unit of the P6 pipeline.
- Consumes the start, MDUOp, V1 and V2 fields delivered by the D/E pipeline register, and owns the HI/LO architectural registers.
- Emits busy back to the D-stage hazard logic, which stalls MDU-class instructions while (start | busy).
- Returns HI or LO on the mf path into the E-stage result mux.

Parameters:
- MULT_CYCLES, 5: busy duration for mult/multu (>=1).
- DIV_CYCLES, 10: busy duration for div/divu (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  qualifies a mult/multu/div/divu in MDUOp this cycle.
- MDUOp  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none.
- A  in  32  operand rs (forwarded E_V1).
- B  in  32  operand rt (forwarded E_V2).
- busy  out  1  operation in flight.
- HI  out  32  current HI register.
- LO  out  32  current LO register.
- mf_out  out  32  HI when MDUOp=5, LO when MDUOp=6, else 0 (combinational).

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (asynchronous, any time, including mid-operation):
  - busy=0, HI=0, LO=0, cycle counter=0, pending result discarded, state=IDLE.
  - mf_out follows MDUOp over zeroed HI/LO.
- States: IDLE, BUSY.
- IDLE:
  - On a rising edge with start=1 and MDUOp in {1,2,3,4}: latch op, compute the 64-bit result {hi,lo} from A/B into a pending register, load counter with MULT_CYCLES or DIV_CYCLES, go BUSY.
  - start=1 with any other MDUOp: ignored.
- BUSY:
  - Counter decrements each edge.
  - On the edge where the counter reaches 1: commit pending to HI/LO, go IDLE.
- Timing: start sampled at edge of cycle t -> busy=1 in cycles t+1..t+N, busy=0 in cycle t+N+1, with new HI/LO visible there. N = MULT_CYCLES or DIV_CYCLES.
- busy is registered, never combinational from start.
- start while BUSY: ignored. Hazard logic guarantees absence; the block must not corrupt state.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
  - multu: unsigned.
  - div: signed, quotient truncated toward zero -> LO, remainder (sign of dividend) -> HI.
  - divu: unsigned.
  - 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0, div or divu): runs full DIV_CYCLES with busy, HI/LO unchanged at commit.
- mthi/mtlo:
  - MDUOp=7/8 with busy=0 writes A into HI/LO at the edge; start is don't-care.
  - Ignored while busy=1.
  - mthi/mtlo in the same cycle a start is accepted: the move is performed, and the later commit overwrites both registers.
- mfhi/mflo: combinational read of architectural HI/LO. During busy it returns the old values; the stall prevents this case architecturally.
- No other state.
- Counter width: clog2(max(MULT_CYCLES,DIV_CYCLES))+1.

Test Plan:
- start, mult, A=0xFFFFFFFD(-3), B=5 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- start, multu, A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE; mf_out with MDUOp=5 = 0x00000001.
- start, div, A=0xFFFFFFF9(-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu on the same operands -> LO=0x7FFFFFFC, HI=1.
- mthi A=0x12345678, then mtlo A=0x9; then div B=0 -> busy 10 cycles, HI=0x12345678 and LO=0x9 preserved.
- start, mult, then a second start/multu with different operands at busy cycle 2 -> second ignored, busy ends at cycle 5, result of the first op only.
- start, div, then assert reset asynchronously mid-cycle at busy cycle 4 -> busy, HI and LO drop to 0 immediately without a clock edge; no later commit occurs.
